// File: rtl/avalon_dma_master.sv
// Avalon-MM DMA master: copies 32-bit words one at a time through a single buffer.
// Optional waitrequest watchdog is enabled by defining AVALON_DMA_TIMEOUT_EN.
module avalon_dma_master #(
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] src_addr,
    input  logic [31:0] dst_addr,
    input  logic [15:0] length,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic        chipselect,
    output logic        read_n,
    output logic        write_n,
    output logic [31:0] address,
    output logic [3:0]  byteEnable_n,
    output logic [31:0] writeData,
    input  logic [31:0] readData,
    input  logic        waitrequest
);
    typedef enum logic [1:0] {IDLE, READ, WRITE, FINISH} state_t;

    state_t      state_q;
    state_t      state_d;
    logic [31:0] src_q;
    logic [31:0] dst_q;
    logic [31:0] src_b;
    logic [31:0] dst_b;
    logic [31:0] addr_d;
    logic [15:0] len_q;
    logic [15:0] idx_q;
    logic [15:0] idx_d;
    logic        tmo;
    logic        abort;
    logic        xfer_d;

`ifdef AVALON_DMA_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] wait_cnt;
    logic             stalled;

    assign stalled = (state_q == READ || state_q == WRITE) && waitrequest;
    assign tmo     = stalled && (wait_cnt == CNT_LAST);

    always_ff @(posedge clk) begin
        if (rst || !stalled || tmo)
            wait_cnt <= '0;
        else
            wait_cnt <= wait_cnt + 1'b1;
    end
`else
    logic unused_cfg;
    assign unused_cfg = ^TIMEOUT_CYCLES;
    assign tmo        = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        abort   = 1'b0;
        src_b   = src_q;
        dst_b   = dst_q;
        unique case (state_q)
            IDLE: begin
                src_b = src_addr;
                dst_b = dst_addr;
                if (start) begin
                    idx_d   = '0;
                    state_d = (length == 16'd0) ? FINISH : READ;
                end
            end
            READ: begin
                if (!waitrequest) begin
                    state_d = WRITE;
                end else if (tmo) begin
                    state_d = FINISH;
                    abort   = 1'b1;
                end
            end
            WRITE: begin
                if (!waitrequest) begin
                    if (idx_q == len_q - 16'd1) begin
                        state_d = FINISH;
                    end else begin
                        idx_d   = idx_q + 16'd1;
                        state_d = READ;
                    end
                end else if (tmo) begin
                    state_d = FINISH;
                    abort   = 1'b1;
                end
            end
            FINISH:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs are registered from the next state so the bus sees them one edge later.
    assign xfer_d = (state_d == READ) || (state_d == WRITE);
    assign addr_d = ((state_d == WRITE) ? dst_b : src_b) + {14'd0, idx_d, 2'b00};

    always_ff @(posedge clk) begin
        if (rst)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            src_q        <= '0;
            dst_q        <= '0;
            len_q        <= '0;
            idx_q        <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            error        <= 1'b0;
            chipselect   <= 1'b0;
            read_n       <= 1'b1;
            write_n      <= 1'b1;
            byteEnable_n <= 4'b1111;
            address      <= '0;
            writeData    <= '0;
        end else begin
            if (state_q == IDLE && start && length != 16'd0) begin
                src_q <= src_addr;
                dst_q <= dst_addr;
                len_q <= length;
            end
            idx_q        <= idx_d;
            busy         <= xfer_d;
            done         <= (state_d == FINISH);
            error        <= abort;
            chipselect   <= xfer_d;
            read_n       <= (state_d != READ);
            write_n      <= (state_d != WRITE);
            byteEnable_n <= xfer_d ? 4'b0000 : 4'b1111;
            address      <= xfer_d ? addr_d : '0;
            if (state_q == READ && !waitrequest)
                writeData <= readData;
        end
    end
endmodule

// File: tb/tb_avalon_dma_master.sv
// Testbench for avalon_dma_master: directed table, corner sequences and
// randomized copies checked against a word-copy memory model.
module tb_avalon_dma_master;
`ifdef AVALON_DMA_TIMEOUT_EN
    localparam int unsigned TMO = 8;
`else
    localparam int unsigned TMO = 1024;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] src_addr;
    logic [31:0] dst_addr;
    logic [15:0] length;
    logic        busy;
    logic        done;
    logic        error;
    logic        chipselect;
    logic        read_n;
    logic        write_n;
    logic [31:0] address;
    logic [3:0]  byteEnable_n;
    logic [31:0] writeData;
    logic [31:0] readData;
    logic        waitrequest;

    int errors = 0;
    int checks = 0;

    logic [31:0] mem [logic [31:0]];
    logic [31:0] mdl [logic [31:0]];
    logic [31:0] obs_addr [$];
    logic [31:0] obs_data [$];
    bit          obs_wr   [$];

    typedef struct {
        logic [31:0] src;
        logic [31:0] dst;
        logic [15:0] len;
        int          stall;
        int          edges;
    } vec_t;

    vec_t vt [5];

    avalon_dma_master #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rst(rst), .start(start),
        .src_addr(src_addr), .dst_addr(dst_addr), .length(length),
        .busy(busy), .done(done), .error(error),
        .chipselect(chipselect), .read_n(read_n), .write_n(write_n),
        .address(address), .byteEnable_n(byteEnable_n),
        .writeData(writeData), .readData(readData),
        .waitrequest(waitrequest)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] fill(input logic [31:0] a);
        return {a[15:0] ^ 16'h5A5A, ~a[31:16]};
    endfunction

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        return mem.exists(a) ? mem[a] : fill(a);
    endfunction

    function automatic logic [31:0] mdl_rd(input logic [31:0] a);
        return mdl.exists(a) ? mdl[a] : fill(a);
    endfunction

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic checki(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        checki({tag, "_ctrl"},
               int'({busy, done, error, chipselect, read_n, write_n}), 3);
        check({tag, "_be"}, {28'h0, byteEnable_n}, 32'hF);
        check({tag, "_addr"}, address, 32'h0);
        check({tag, "_wdata"}, writeData, 32'h0);
    endtask

    // One copy with a slave that stalls each transfer; exp_edges < 0 means
    // the expected latency is 2*n plus the stalls the slave inserted.
    task automatic run_copy(input logic [31:0] s, input logic [31:0] d,
                            input logic [15:0] n, input int stall,
                            input bit rnd, input int exp_edges,
                            input int poke, input bit fin_poke,
                            input string tag);
        logic [31:0] ex_addr [$];
        logic [31:0] ex_data [$];
        bit          ex_wr   [$];
        logic [66:0] prev_v;
        logic [66:0] cur_v;
        bit          prev_st;
        int          stalls;
        int          viol;
        int          done_t;
        int          rem;
        int          budget;
        int          mism;
        int          exp_e;
        logic        err_at_done;
        stalls = 0; viol = 0; done_t = -1; rem = -1; prev_st = 0;
        prev_v = '0; err_at_done = 1'b0; mism = 0;
        obs_addr.delete(); obs_data.delete(); obs_wr.delete();
        for (int k = 0; k < int'(n); k++) begin
            logic [31:0] a;
            logic [31:0] b;
            logic [31:0] v;
            a = s + 32'(k) * 32'd4;
            b = d + 32'(k) * 32'd4;
            v = mdl_rd(a);
            ex_addr.push_back(a); ex_data.push_back(v); ex_wr.push_back(0);
            ex_addr.push_back(b); ex_data.push_back(v); ex_wr.push_back(1);
            mdl[b] = v;
        end
        budget = 2 * int'(n) * (stall + 1) + 20;
        @(negedge clk);
        start = 1'b1; src_addr = s; dst_addr = d; length = n;
        waitrequest = 1'b0;
        for (int t = 1; t <= budget && done_t < 0; t++) begin
            @(negedge clk);
            start = 1'b0;
            if (t == poke) begin
                start = 1'b1; src_addr = 32'hBAD0;
                dst_addr = 32'hBEE0; length = 16'd7;
            end
            cur_v = {chipselect, read_n, write_n, address, writeData};
            if (!read_n && !write_n) viol++;
            if (chipselect == (read_n && write_n)) viol++;
            if (byteEnable_n !== (chipselect ? 4'h0 : 4'hF)) viol++;
            if (prev_st && cur_v !== prev_v) viol++;
            if (done) begin
                done_t = t;
                err_at_done = error;
            end else if (busy !== (n != 16'd0)) begin
                viol++;
            end
            prev_v = cur_v;
            prev_st = 0;
            waitrequest = 1'b0;
            readData = $urandom;
            if (chipselect) begin
                if (rem < 0)
                    rem = rnd ? int'($urandom_range(stall)) : stall;
                if (rem > 0) begin
                    waitrequest = 1'b1;
                    rem--;
                    stalls++;
                    prev_st = 1;
                end else begin
                    rem = -1;
                    obs_addr.push_back(address);
                    obs_wr.push_back(!write_n);
                    obs_data.push_back(writeData);
                    if (!read_n) readData = mem_rd(address);
                    else mem[address] = writeData;
                end
            end
        end
        if (fin_poke) begin
            start = 1'b1; src_addr = 32'hC000;
            dst_addr = 32'hD000; length = 16'd2;
        end
        @(negedge clk);
        start = 1'b0;
        checki({tag, "_pulse"}, int'({done, error, busy}), 0);
        if (fin_poke) begin
            int v2;
            v2 = 0;
            repeat (3) begin
                @(negedge clk);
                if (chipselect || done) v2++;
            end
            checki({tag, "_fin_ignored"}, v2, 0);
        end
        exp_e = (exp_edges >= 0) ? exp_edges : 2 * int'(n) + stalls;
        checki({tag, "_done_seen"}, int'(done_t > 0), 1);
        checki({tag, "_latency"}, done_t - 1, exp_e);
        checki({tag, "_error"}, int'(err_at_done), 0);
        checki({tag, "_ntxn"}, obs_addr.size(), ex_addr.size());
        for (int k = 0; k < obs_addr.size() && k < ex_addr.size(); k++) begin
            if (obs_addr[k] !== ex_addr[k] || obs_wr[k] != ex_wr[k] ||
                (ex_wr[k] && obs_data[k] !== ex_data[k])) begin
                if (mism == 0)
                    $display("FAIL %s_txn%0d: got wr=%0d %h/%h expected wr=%0d %h/%h",
                             tag, k, obs_wr[k], obs_addr[k], obs_data[k],
                             ex_wr[k], ex_addr[k], ex_data[k]);
                mism++;
            end
        end
        checki({tag, "_txn_mismatches"}, mism, 0);
        checki({tag, "_protocol"}, viol, 0);
    endtask

    initial begin
        bit seen;
        int dt;
        int viol;
        logic er;
        logic [2:0] strb;
        logic [31:0] s;
        logic [31:0] d;

        vt[0] = '{32'h0000_0100, 32'h0000_0200, 16'd3, 0, 6};
        vt[1] = '{32'h0000_1000, 32'h0000_2000, 16'd1, 2, 6};
        vt[2] = '{32'h0000_0300, 32'h0000_0400, 16'd0, 0, 0};
        vt[3] = '{32'hFFFF_FFFC, 32'h0000_0500, 16'd2, 0, 4};
        vt[4] = '{32'h0000_0010, 32'hFFFF_FFF8, 16'd4, 1, 16};

        rst = 1'b1; start = 1'b0; src_addr = '0; dst_addr = '0;
        length = '0; waitrequest = 1'b0; readData = '0;
        mem[32'h1000] = 32'hDEADBEEF;
        mdl[32'h1000] = 32'hDEADBEEF;

        repeat (2) @(negedge clk);
        check_reset_vals("reset");
        rst = 1'b0;

        for (int i = 0; i < 5; i++) begin
            run_copy(vt[i].src, vt[i].dst, vt[i].len, vt[i].stall, 0,
                     vt[i].edges, 0, 0, $sformatf("vec%0d", i));
            if (i == 0) begin
                check("vec0_rd1", obs_addr[2], 32'h104);
                check("vec0_wr2", obs_addr[5], 32'h208);
            end
            if (i == 1) begin
                check("vec1_waddr", obs_addr[1], 32'h2000);
                check("vec1_wdata", obs_data[1], 32'hDEADBEEF);
            end
            if (i == 3)
                check("vec3_wrap_rd", obs_addr[2], 32'h0000_0000);
        end

        run_copy(32'h1200, 32'h1300, 16'd3, 1, 0, 12, 3, 0, "busy_poke");
        run_copy(32'h1400, 32'h1500, 16'd2, 0, 0, 4, 0, 1, "fin_poke");

        // Reset while a write is stalled, then a fresh copy.
        @(negedge clk);
        start = 1'b1; src_addr = 32'h700; dst_addr = 32'h800; length = 16'd2;
        seen = 0;
        for (int t = 0; t < 10 && !seen; t++) begin
            @(negedge clk);
            start = 1'b0;
            waitrequest = 1'b0;
            readData = mem_rd(address);
            if (!write_n) begin
                waitrequest = 1'b1;
                seen = 1;
            end
        end
        checki("rstw_reach_write", int'(seen), 1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        waitrequest = 1'b0;
        check_reset_vals("rstw");
        run_copy(32'h700, 32'h800, 16'd2, 0, 0, 4, 0, 0, "after_rst");

        for (int r = 0; r < 20; r++) begin
            s = 32'h4000 + (32'($urandom_range(63)) << 2);
            d = 32'h4000 + (32'($urandom_range(63)) << 2);
            if (r % 5 == 4) s = 32'hFFFF_FFF0 + (32'($urandom_range(3)) << 2);
            run_copy(s, d, 16'($urandom_range(8, 1)), 3, 1, -1, 0, 0,
                     $sformatf("rnd%0d", r));
        end

        // Slave that never releases waitrequest.
        @(negedge clk);
        start = 1'b1; src_addr = 32'h900; dst_addr = 32'hA00; length = 16'd3;
        waitrequest = 1'b1;
        dt = -1; er = 1'b0; strb = '0; viol = 0;
`ifdef AVALON_DMA_TIMEOUT_EN
        for (int t = 1; t <= 30 && dt < 0; t++) begin
            @(negedge clk);
            start = 1'b0;
            if (done) begin
                dt = t;
                er = error;
                strb = {chipselect, read_n, write_n};
            end
        end
        checki("tmo_done_cycle", dt, int'(TMO) + 1);
        checki("tmo_error", int'(er), 1);
        checki("tmo_strobe", int'(strb), 3);
        waitrequest = 1'b0;
        @(negedge clk);
        checki("tmo_pulse", int'({done, error}), 0);
`else
        for (int t = 1; t <= 100; t++) begin
            @(negedge clk);
            start = 1'b0;
            if (!chipselect || read_n || done || error) viol++;
        end
        checki("stall_hold", viol, 0);
        check("stall_addr", address, 32'h900);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        waitrequest = 1'b0;
        check_reset_vals("stall_rst");
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
